// File: rtl/spi_matrix_receiver_pkg.sv
// Shared definitions for the MAX7219-style SPI shadow receiver:
// register addresses and the frame FSM encoding.
package spi_matrix_receiver_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT1    = 4'h2;
    localparam logic [3:0] REG_DIGIT2    = 4'h3;
    localparam logic [3:0] REG_DIGIT3    = 4'h4;
    localparam logic [3:0] REG_DIGIT4    = 4'h5;
    localparam logic [3:0] REG_DIGIT5    = 4'h6;
    localparam logic [3:0] REG_DIGIT6    = 4'h7;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_DECODE    = 4'h9;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SCANLIM   = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
    localparam logic [3:0] REG_TEST      = 4'hF;

    localparam logic [4:0] BIT_CNT_MAX   = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

endpackage

// File: rtl/spi_matrix_receiver_sync_edge.sv
// N-stage synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized copy.
module sync_edge #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    // Shift the raw input through the chain; remember the previous output.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_matrix_receiver.sv
// Passive SPI listener that decodes MAX7219 command frames and keeps a
// shadow of the display registers for preview and self-check.
module spi_matrix_receiver
    import spi_matrix_receiver_pkg::*;
#(
    parameter int PAIR_BYTES  = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mosi,
    input  logic       sclk,
    input  logic       cs,
    input  logic [2:0] row_sel,
    output logic [7:0] row_out,
    output logic       shutdown_n,
    output logic [7:0] decode_mode,
    output logic [3:0] intensity,
    output logic [2:0] scan_limit,
    output logic       display_test,
    output logic       frame_valid,
    output logic [7:0] frame_addr,
    output logic [7:0] frame_data,
    output logic       frame_err
);

    logic sclk_s, sclk_rise_s, sclk_fall_s;
    logic cs_s, cs_rise_s, cs_fall_s;
    logic mosi_s;

    // cs resets low so a window already open at reset release never commits.
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .d(sclk),
        .q(sclk_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );
    sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_cs_sync (
        .clk(clk), .reset(reset), .d(cs),
        .q(cs_s), .rise(cs_rise_s), .fall(cs_fall_s)
    );

    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    state_e          state_q, state_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     sr_q, sr_d;
    logic            holder_full_q, holder_full_d;
    logic [7:0]      holder_addr_q, holder_addr_d;
    logic            pend_valid_q, pend_valid_d;
    logic            pend_err_q, pend_err_d;
    logic [7:0]      pend_addr_q, pend_addr_d;
    logic [7:0]      pend_data_q, pend_data_d;
    logic [7:0][7:0] rows_q, rows_d;
    logic            shutdown_q, shutdown_d;
    logic [7:0]      decode_q, decode_d;
    logic [3:0]      intensity_q, intensity_d;
    logic [2:0]      scan_q, scan_d;
    logic            test_q, test_d;
    logic            frame_valid_q, frame_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      frame_addr_q, frame_addr_d;
    logic [7:0]      frame_data_q, frame_data_d;
    logic [2:0]      row_idx_s;

    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    // Digit addresses 1..8 map to rows 0..7; 8 wraps to 7 in three bits.
    assign row_idx_s = pend_addr_q[2:0] - 3'd1;

    // Frame FSM: shift, classify on cs rise, apply decode in COMMIT.
    always_comb begin
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        holder_full_d = holder_full_q;
        holder_addr_d = holder_addr_q;
        pend_valid_d  = pend_valid_q;
        pend_err_d    = pend_err_q;
        pend_addr_d   = pend_addr_q;
        pend_data_d   = pend_data_q;
        rows_d        = rows_q;
        shutdown_d    = shutdown_q;
        decode_d      = decode_q;
        intensity_d   = intensity_q;
        scan_d        = scan_q;
        test_d        = test_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_addr_d  = frame_addr_q;
        frame_data_d  = frame_data_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall_s) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 5'd0;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    state_d      = ST_COMMIT;
                    pend_valid_d = 1'b0;
                    pend_err_d   = 1'b0;
                    if (PAIR_BYTES == 0) begin
                        if (bit_cnt_q == 5'd16) begin
                            pend_valid_d = 1'b1;
                            pend_addr_d  = sr_q[15:8];
                            pend_data_d  = sr_q[7:0];
                        end else begin
                            pend_err_d   = 1'b1;
                        end
                    end else begin
                        if (bit_cnt_q != 5'd8) begin
                            pend_err_d    = 1'b1;
                            holder_full_d = 1'b0;
                        end else if (holder_full_q) begin
                            pend_valid_d  = 1'b1;
                            pend_addr_d   = holder_addr_q;
                            pend_data_d   = sr_q[7:0];
                            holder_full_d = 1'b0;
                        end else begin
                            holder_full_d = 1'b1;
                            holder_addr_d = sr_q[7:0];
                        end
                    end
                end else if (sclk_rise_s) begin
                    sr_d      = {sr_q[14:0], mosi_s};
                    bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? BIT_CNT_MAX : bit_cnt_q + 5'd1;
                end else begin
                    state_d   = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
                state_d       = ST_IDLE;
                frame_valid_d = pend_valid_q;
                frame_err_d   = pend_err_q;
                if (pend_valid_q) begin
                    frame_addr_d = pend_addr_q;
                    frame_data_d = pend_data_q;
                    case (pend_addr_q[3:0])
                        REG_DIGIT0, REG_DIGIT1, REG_DIGIT2, REG_DIGIT3,
                        REG_DIGIT4, REG_DIGIT5, REG_DIGIT6, REG_DIGIT7:
                                       rows_d[row_idx_s] = pend_data_q;
                        REG_DECODE:    decode_d    = pend_data_q;
                        REG_INTENSITY: intensity_d = pend_data_q[3:0];
                        REG_SCANLIM:   scan_d      = pend_data_q[2:0];
                        REG_SHUTDOWN:  shutdown_d  = pend_data_q[0];
                        REG_TEST:      test_d      = pend_data_q[0];
                        REG_NOOP:      test_d      = test_q;
                        default:       test_d      = test_q;
                    endcase
                end else begin
                    frame_addr_d = frame_addr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and shadow register flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mosi_sync_q   <= '0;
            state_q       <= ST_IDLE;
            bit_cnt_q     <= 5'd0;
            sr_q          <= 16'h0000;
            holder_full_q <= 1'b0;
            holder_addr_q <= 8'h00;
            pend_valid_q  <= 1'b0;
            pend_err_q    <= 1'b0;
            pend_addr_q   <= 8'h00;
            pend_data_q   <= 8'h00;
            rows_q        <= '0;
            shutdown_q    <= 1'b0;
            decode_q      <= 8'h00;
            intensity_q   <= 4'h0;
            scan_q        <= 3'd0;
            test_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_addr_q  <= 8'h00;
            frame_data_q  <= 8'h00;
        end else begin
            mosi_sync_q   <= mosi_sync_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            holder_full_q <= holder_full_d;
            holder_addr_q <= holder_addr_d;
            pend_valid_q  <= pend_valid_d;
            pend_err_q    <= pend_err_d;
            pend_addr_q   <= pend_addr_d;
            pend_data_q   <= pend_data_d;
            rows_q        <= rows_d;
            shutdown_q    <= shutdown_d;
            decode_q      <= decode_d;
            intensity_q   <= intensity_d;
            scan_q        <= scan_d;
            test_q        <= test_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            frame_addr_q  <= frame_addr_d;
            frame_data_q  <= frame_data_d;
        end
    end

    assign row_out      = rows_q[row_sel];
    assign shutdown_n   = shutdown_q;
    assign decode_mode  = decode_q;
    assign intensity    = intensity_q;
    assign scan_limit   = scan_q;
    assign display_test = test_q;
    assign frame_valid  = frame_valid_q;
    assign frame_err    = frame_err_q;
    assign frame_addr   = frame_addr_q;
    assign frame_data   = frame_data_q;

    logic unused_s;
    assign unused_s = sclk_s ^ sclk_fall_s ^ cs_s;

endmodule

// File: tb/tb_spi_matrix_receiver.sv
// Directed bench: one paired-byte and one 16-bit-frame receiver share the bus.
module tb_spi_matrix_receiver;

    localparam int SYNC = 2;

    logic       clk = 1'b0, reset = 1'b1, mosi = 1'b0, sclk = 1'b0, cs = 1'b1;
    logic [2:0] row_sel = 3'd0;

    logic [7:0] p_row, p_dec, p_fa, p_fd, w_row, w_dec, w_fa, w_fd;
    logic [3:0] p_int, w_int;
    logic [2:0] p_scan, w_scan;
    logic       p_shdn, p_test, p_valid, p_err, w_shdn, w_test, w_valid, w_err;

    spi_matrix_receiver #(.PAIR_BYTES(1), .SYNC_STAGES(SYNC)) u_pair (
        .clk(clk), .reset(reset), .mosi(mosi), .sclk(sclk), .cs(cs),
        .row_sel(row_sel), .row_out(p_row), .shutdown_n(p_shdn),
        .decode_mode(p_dec), .intensity(p_int), .scan_limit(p_scan),
        .display_test(p_test), .frame_valid(p_valid), .frame_addr(p_fa),
        .frame_data(p_fd), .frame_err(p_err)
    );

    spi_matrix_receiver #(.PAIR_BYTES(0), .SYNC_STAGES(SYNC)) u_word (
        .clk(clk), .reset(reset), .mosi(mosi), .sclk(sclk), .cs(cs),
        .row_sel(row_sel), .row_out(w_row), .shutdown_n(w_shdn),
        .decode_mode(w_dec), .intensity(w_int), .scan_limit(w_scan),
        .display_test(w_test), .frame_valid(w_valid), .frame_addr(w_fa),
        .frame_data(w_fd), .frame_err(w_err)
    );

    always #5 clk = ~clk;

    int p_vcnt = 0, p_ecnt = 0, w_vcnt = 0, w_ecnt = 0;
    always @(posedge clk) begin
        if (p_valid) p_vcnt <= p_vcnt + 1;
        if (p_err)   p_ecnt <= p_ecnt + 1;
        if (w_valid) w_vcnt <= w_vcnt + 1;
        if (w_err)   w_ecnt <= w_ecnt + 1;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } pair_t;

    pair_t      tbl [13];
    logic [7:0] exp_rows [8];
    int         n_checks = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic shift_bits(input logic [31:0] val, input int n);
        cs = 1'b0;
        #40;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = val[i];
            #40; sclk = 1'b1;
            #40; sclk = 1'b0;
        end
        #40;
    endtask

    // Raise cs on a falling clk edge and report the cycle frame_valid of the word DUT appears.
    task automatic raise_cs(output int lat);
        lat = 0;
        @(negedge clk);
        cs = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (w_valid && lat == 0) lat = k;
        end
    endtask

    task automatic send(input logic [31:0] val, input int n);
        int l;
        shift_bits(val, n);
        raise_cs(l);
    endtask

    task automatic send_pair(input logic [7:0] a, input logic [7:0] d);
        send({24'h0, a}, 8);
        send({24'h0, d}, 8);
    endtask

    task automatic rd_row(input logic [2:0] s, output logic [7:0] v);
        @(negedge clk);
        row_sel = s;
        #1;
        v = p_row;
    endtask

    initial begin
        int         v0, e0, lat;
        logic [7:0] r;

        tbl[0]  = '{8'h0C, 8'h01}; tbl[1]  = '{8'h09, 8'h00}; tbl[2]  = '{8'h0A, 8'h0A};
        tbl[3]  = '{8'h0B, 8'h07}; tbl[4]  = '{8'h0F, 8'h00};
        tbl[5]  = '{8'h01, 8'hFF}; tbl[6]  = '{8'h02, 8'h81}; tbl[7]  = '{8'h03, 8'hA5};
        tbl[8]  = '{8'h04, 8'h81}; tbl[9]  = '{8'h05, 8'hA5}; tbl[10] = '{8'h06, 8'h99};
        tbl[11] = '{8'h07, 8'h81}; tbl[12] = '{8'h08, 8'hFF};
        exp_rows = '{8'hFF, 8'h81, 8'hA5, 8'h81, 8'hA5, 8'h99, 8'h81, 8'hFF};

        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rd_row(3'(i), r);
            chk($sformatf("reset_row%0d", i), {24'h0, r}, 32'h0);
        end
        chk("reset_shutdown", {31'h0, p_shdn}, 32'h0);
        chk("reset_intensity", {28'h0, p_int}, 32'h0);
        chk("reset_frame_addr", {24'h0, p_fa}, 32'h0);
        chk("reset_pulses", p_vcnt + p_ecnt, 0);

        for (int i = 0; i < 13; i++) begin
            v0 = p_vcnt;
            send_pair(tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_valid_pulses", i), p_vcnt - v0, 1);
            chk($sformatf("tbl%0d_frame_addr", i), {24'h0, p_fa}, {24'h0, tbl[i].addr});
            chk($sformatf("tbl%0d_frame_data", i), {24'h0, p_fd}, {24'h0, tbl[i].data});
        end
        chk("boot_shutdown_n", {31'h0, p_shdn}, 32'h1);
        chk("boot_decode_mode", {24'h0, p_dec}, 32'h00);
        chk("boot_intensity", {28'h0, p_int}, 32'hA);
        chk("boot_scan_limit", {29'h0, p_scan}, 32'h7);
        chk("boot_display_test", {31'h0, p_test}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_row(3'(i), r);
            chk($sformatf("row%0d", i), {24'h0, r}, {24'h0, exp_rows[i]});
        end

        // Zero-bit cs glitch
        e0 = p_ecnt;
        @(negedge clk); cs = 1'b0;
        repeat (3) @(negedge clk); cs = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_err", p_ecnt - e0, 1);

        // Half a pair, a 5-bit window, then 01/3C: the 5-bit window must drop the held address
        send(32'h03, 8);
        e0 = p_ecnt; v0 = p_vcnt;
        send(32'h15, 5);
        chk("short_err", p_ecnt - e0, 1);
        send_pair(8'h01, 8'h3C);
        chk("short_then_pair_valid", p_vcnt - v0, 1);
        rd_row(3'd0, r);
        chk("short_row0", {24'h0, r}, 32'h3C);
        rd_row(3'd2, r);
        chk("short_row2_kept", {24'h0, r}, 32'hA5);

        // 16-bit frame mode with latency, then an over-length frame
        v0 = w_vcnt;
        shift_bits(32'h0A05, 16);
        raise_cs(lat);
        chk("word_valid", w_vcnt - v0, 1);
        chk("word_latency", lat, SYNC + 2);
        chk("word_intensity", {28'h0, w_int}, 32'h5);
        chk("word_frame_addr", {24'h0, w_fa}, 32'h0A);
        e0 = w_ecnt; v0 = w_vcnt;
        send(32'h0A07, 17);
        chk("word17_err", w_ecnt - e0, 1);
        chk("word17_no_valid", w_vcnt - v0, 0);
        chk("word17_intensity", {28'h0, w_int}, 32'h5);

        // Reset halfway through the data byte of pair 02/AA
        send(32'h02, 8);
        shift_bits(32'hA, 4);
        reset = 1'b1;
        #30;
        reset = 1'b0;
        v0 = p_vcnt; e0 = p_ecnt;
        shift_bits(32'hA, 4);
        raise_cs(lat);
        chk("rst_mid_no_valid", p_vcnt - v0, 0);
        chk("rst_mid_no_err", p_ecnt - e0, 0);
        rd_row(3'd1, r);
        chk("rst_mid_row1", {24'h0, r}, 32'h00);
        rd_row(3'd0, r);
        chk("rst_mid_row0", {24'h0, r}, 32'h00);
        send_pair(8'h02, 8'hAA);
        rd_row(3'd1, r);
        chk("rst_after_row1", {24'h0, r}, 32'hAA);
        chk("rst_after_valid", p_vcnt - v0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_matrix_receiver.md
Name: spi_matrix_receiver

Overview:
- SPI slave that decodes the MAX7219-style command stream our matrix drivers emit and keeps a shadow copy of the display registers.
- Gives the FPGA a readable image of what the 8x8 matrix should show, for on-board preview, self-check and bench scoreboarding.
- Sits on the same mosi/sclk/cs wires as the external matrix and never drives them.

Parameters:
- PAIR_BYTES, 1, 1: each cs-low window carries 8 bits; two consecutive windows form an address/data pair. 0: one 16-bit frame per window.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizers (minimum 2).

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency
- reset  in  1  asynchronous, active-high reset
- mosi  in  1  serial data, MSB first
- sclk  in  1  SPI clock, asynchronous to clk
- cs  in  1  chip select, active low, asynchronous to clk
- row_sel  in  3  digit-row read address
- row_out  out  8  row register selected by row_sel (combinational read)
- shutdown_n  out  1  register 0x0C bit 0
- decode_mode  out  8  register 0x09
- intensity  out  4  register 0x0A[3:0]
- scan_limit  out  3  register 0x0B[2:0]
- display_test  out  1  register 0x0F bit 0
- frame_valid  out  1  one-cycle pulse when a complete address/data pair is committed
- frame_addr  out  8  address of the last committed frame
- frame_data  out  8  data of the last committed frame
- frame_err  out  1  one-cycle pulse when cs rises with a wrong bit count

Behaviour:
- Reset: all rows 0x00; shutdown_n=0, decode_mode=0x00, intensity=0x0, scan_limit=0, display_test=0; frame_valid=0, frame_err=0, frame_addr=0x00, frame_data=0x00. The pair holder is empty and the bit counter is 0.
- Synchronization: mosi, sclk and cs each pass through SYNC_STAGES flops. Edges of sclk and cs are detected on the synchronized copies.
- Shift: on a synchronized sclk rising edge while cs is low, shift mosi into a 16-bit shift register (MSB first). The bit counter increments and saturates at 31.
- cs falling edge: clear the bit counter.
- cs rising edge with PAIR_BYTES=0:
  - exactly 16 bits: commit addr=sr[15:8], data=sr[7:0].
  - any other count: pulse frame_err; nothing is committed.
- cs rising edge with PAIR_BYTES=1:
  - exactly 8 bits and the pair holder is empty: store sr[7:0] as the address.
  - exactly 8 bits and the holder is full: commit that stored address with data=sr[7:0], then empty the holder.
  - any other count: pulse frame_err and empty the holder.
- Commit, effective one cycle after the synchronized cs rising edge:
  - frame_valid=1 for one cycle; frame_addr and frame_data update.
  - Address decode uses addr[3:0]; addr[7:4] is ignored, as on the MAX7219.
  - 0x1–0x8 write row addr-1.
  - 0x9, 0xA, 0xB, 0xC and 0xF write their respective registers.
  - 0x0 (no-op), 0xD and 0xE write nothing, but frame_valid still pulses.
- Total latency from the cs rising edge on the pin to frame_valid: SYNC_STAGES+2 clk cycles.
- Edges: an sclk edge coincident with the cs rising edge is ignored. A glitch pulse on cs with 0 bits is a count mismatch and produces frame_err.
- Reset mid-frame clears all state. A cs-low window that is already in progress at reset release is discarded: the first cs rising edge seen after reset is ignored.
- The pair holder has no timeout.
- FSM states: IDLE (cs high), SHIFT (cs low), COMMIT (one cycle). Transitions:
  - IDLE→SHIFT on cs falling edge.
  - SHIFT→COMMIT on cs rising edge.
  - COMMIT→IDLE unconditionally.
  - Any state→IDLE on reset.

Decomposition:
- Shared package holds:
  - register address constants: REG_NOOP=0x0, REG_DIGIT0=0x1 … REG_DIGIT7=0x8, REG_DECODE=0x9, REG_INTENSITY=0xA, REG_SCANLIM=0xB, REG_SHUTDOWN=0xC, REG_TEST=0xF;
  - the FSM state encoding.
- One natural sub-module: sync_edge (an N-stage synchronizer with rise/fall pulse outputs), instantiated once each for sclk and cs; mosi uses only its synchronized output.

Test Plan:
- Reset then read back → every row_sel returns 0x00, shutdown_n=0, no pulses.
- PAIR_BYTES=1, send the boot sequence 0C/01, 09/00, 0A/0A, 0B/07, 0F/00 → shutdown_n=1, decode_mode=0x00, intensity=0xA, scan_limit=7, display_test=0, five frame_valid pulses.
- PAIR_BYTES=1, write rows 1–8 with FF,81,A5,81,A5,99,81,FF → row_out for row_sel 0..7 matches those bytes; frame_addr=0x08, frame_data=0xFF after the last pair.
- PAIR_BYTES=1, a 5-bit cs window, then pair 01/3C → frame_err pulses once; the holder is cleared; row 0=0x3C.
- PAIR_BYTES=0, 16-bit frame 0x0A05 → intensity=0x5 with SYNC_STAGES+2-cycle latency; a 17-bit frame → frame_err and intensity stays 0x5.
- Assert reset halfway through the 8-bit data byte of pair 02/AA → no commit, row 1=0x00; the next full pair 02/AA → row 1=0xAA.
